booth_pp_gen_pipe: RTL and testbench

//  Parametrised, pipelined radix-4 Booth partial-product generator for the Wallace-tree multiplier.

---
 rtl/booth_pp_gen_pipe.sv | 122 ++++++++++++
 tb/tb_booth_pp_gen_pipe.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/booth_pp_gen_pipe.sv
// Two-stage radix-4 Booth partial-product generator feeding the Wallace tree.
// Stage 1 latches the extended multiplicand and one-hot Booth digits; stage 2 the shifted partial products.
module booth_pp_gen_pipe #(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic                                     mul_clk,
  input  logic                                     reset,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic                                     in_signed,
  input  logic [WIDTH-1:0]                         in_a,
  input  logic [WIDTH-1:0]                         in_b,
  input  logic [TAG_W-1:0]                         in_tag,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [(WIDTH/2+1)*(2*WIDTH+2)-1:0]       out_pp,
  output logic [TAG_W-1:0]                         out_tag
);

  localparam int NPP  = WIDTH / 2 + 1;
  localparam int PP_W = 2 * WIDTH + 2;

  typedef struct packed {
    logic zero;
    logic one;
    logic two;
    logic neg1;
    logic neg2;
  } booth_oh_t;

  logic                      e_a;
  logic                      e_b;
  logic [WIDTH:0]            a_ext_d;
  logic [WIDTH+2:0]          b_ext;
  booth_oh_t [NPP-1:0]       dig_d;

  logic                      s1_valid_q;
  logic [WIDTH:0]            s1_a_q;
  booth_oh_t [NPP-1:0]       s1_dig_q;
  logic [TAG_W-1:0]          s1_tag_q;

  logic                      s2_valid_q;
  logic [NPP*PP_W-1:0]       pp_d;
  logic [NPP*PP_W-1:0]       pp_q;
  logic [TAG_W-1:0]          tag_q;

  logic [PP_W-1:0]           a_sx;
  logic [PP_W-1:0]           sel;

  logic                      s1_ready;
  logic                      s2_ready;

  assign s2_ready  = ~s2_valid_q | out_ready;
  assign s1_ready  = ~s1_valid_q | s2_ready;
  assign in_ready  = s1_ready;
  assign out_valid = s2_valid_q;
  assign out_pp    = pp_q;
  assign out_tag   = tag_q;

  assign e_a     = in_signed & in_a[WIDTH-1];
  assign e_b     = in_signed & in_b[WIDTH-1];
  assign a_ext_d = {e_a, in_a};
  assign b_ext   = {e_b, e_b, in_b, 1'b0};

  always_comb begin
    for (int i = 0; i < NPP; i++) begin
      // NOTE: every bit gets a default before the case so no latch is inferred.
      dig_d[i] = '0;
      case (b_ext[2*i +: 3])
        3'b001, 3'b010: dig_d[i].one  = 1'b1;
        3'b011:         dig_d[i].two  = 1'b1;
        3'b100:         dig_d[i].neg2 = 1'b1;
        3'b101, 3'b110: dig_d[i].neg1 = 1'b1;
        default:        dig_d[i].zero = 1'b1;
      endcase
    end
  end

  // Negation is a full two's complement inside the PP_W field, so the tree needs no carry-in bits.
  always_comb begin
    a_sx = {{(PP_W-WIDTH-1){s1_a_q[WIDTH]}}, s1_a_q};
    pp_d = '0;
    sel  = '0;
    for (int i = 0; i < NPP; i++) begin
      if (s1_dig_q[i].zero)      sel = '0;
      else if (s1_dig_q[i].one)  sel = a_sx;
      else if (s1_dig_q[i].two)  sel = a_sx << 1;
      else if (s1_dig_q[i].neg1) sel = ~a_sx + 1'b1;
      else if (s1_dig_q[i].neg2) sel = ~(a_sx << 1) + 1'b1;
      else                       sel = '0;
      pp_d[i*PP_W +: PP_W] = sel << (2*i);
    end
  end

  always_ff @(posedge mul_clk) begin
    // NOTE: data registers are cleared too, so out_pp/out_tag read zero straight after reset.
    if (reset) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_dig_q   <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      pp_q       <= '0;
      tag_q      <= '0;
    end else begin
      // NOTE: non-blocking updates let both stages advance on the same edge without ordering races.
      if (s1_ready) s1_valid_q <= in_valid;
      if (in_valid && s1_ready) begin
        s1_a_q   <= a_ext_d;
        s1_dig_q <= dig_d;
        s1_tag_q <= in_tag;
      end
      if (s2_ready) s2_valid_q <= s1_valid_q;
      if (s1_valid_q && s2_ready) begin
        pp_q  <= pp_d;
        tag_q <= s1_tag_q;
      end
    end
  end

endmodule

// File: tb/tb_booth_pp_gen_pipe.sv
// Directed bench for booth_pp_gen_pipe: hand-computed vectors at WIDTH=8 and WIDTH=32,
// stall/ordering, reset flush and a random scoreboard run against a product model.
module tb_booth_pp_gen_pipe;

  localparam int W8   = 8;
  localparam int NPP8 = W8 / 2 + 1;
  localparam int PPW8 = 2 * W8 + 2;
  localparam int W32   = 32;
  localparam int NPP32 = W32 / 2 + 1;
  localparam int PPW32 = 2 * W32 + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   reset;
  logic                   in_valid, in_ready, in_signed, out_valid, out_ready;
  logic [W8-1:0]          in_a, in_b;
  logic [3:0]             in_tag, out_tag;
  logic [NPP8*PPW8-1:0]   out_pp;

  logic                   c_in_valid, c_in_ready, c_in_signed, c_out_valid, c_out_ready;
  logic [W32-1:0]         c_in_a, c_in_b;
  logic [3:0]             c_in_tag, c_out_tag;
  logic [NPP32*PPW32-1:0] c_out_pp;

  booth_pp_gen_pipe #(.WIDTH(W8), .TAG_W(4)) dut8 (
    .mul_clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_signed(in_signed), .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_pp(out_pp), .out_tag(out_tag)
  );

  booth_pp_gen_pipe #(.WIDTH(W32), .TAG_W(4)) dut32 (
    .mul_clk(clk), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_signed(c_in_signed), .in_a(c_in_a), .in_b(c_in_b), .in_tag(c_in_tag),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_pp(c_out_pp), .out_tag(c_out_tag)
  );

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [PPW8-1:0] sum8(input logic [NPP8*PPW8-1:0] pp);
    logic [PPW8-1:0] s;
    s = '0;
    for (int i = 0; i < NPP8; i++) s += pp[i*PPW8 +: PPW8];
    return s;
  endfunction

  function automatic logic [PPW32-1:0] sum32(input logic [NPP32*PPW32-1:0] pp);
    logic [PPW32-1:0] s;
    s = '0;
    for (int i = 0; i < NPP32; i++) s += pp[i*PPW32 +: PPW32];
    return s;
  endfunction

  task automatic drive8(input logic sgn, input logic [7:0] a, input logic [7:0] b, input logic [3:0] tag);
    in_signed = sgn;
    in_a      = a;
    in_b      = b;
    in_tag    = tag;
    in_valid  = 1'b1;
  endtask

  typedef struct {
    logic            sgn;
    logic [7:0]      a;
    logic [7:0]      b;
    logic [3:0]      tag;
    logic [PPW8-1:0] exp_sum;
    logic            chk4;
    logic [PPW8-1:0] exp_pp4;
  } vec_t;

  typedef struct {
    logic [3:0]      tag;
    logic [PPW8-1:0] exp_sum;
  } sb_t;

  task automatic run32(input string name, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tag, input logic [PPW32-1:0] exp);
    int lat;
    @(negedge clk);
    c_in_signed = sgn; c_in_a = a; c_in_b = b; c_in_tag = tag; c_in_valid = 1'b1;
    c_out_ready = 1'b1;
    @(posedge clk); #1;
    c_in_valid = 1'b0;
    lat = 0;
    do begin @(negedge clk); lat++; end while (!c_out_valid && lat < 10);
    check({name, "_latency"}, 66'(lat), 66'd2);
    check({name, "_sum"}, sum32(c_out_pp), exp);
    check({name, "_tag"}, c_out_tag, tag);
  endtask

  vec_t vecs[10];
  vec_t ops4[4];
  sb_t  sbq[$];

  initial begin
    int lat, idx, ngot, first_c, last_c, seen, sent, got, cyc;
    logic rdy, acc_in, acc_out;
    logic [NPP8*PPW8-1:0] held_pp;
    logic [3:0] held_tag;
    logic [3:0] got_tag[8];
    logic [PPW8-1:0] got_sum[8];
    logic [PPW32-1:0] all1;
    sb_t e;
    int av, bv, prod;

    vecs[0] = '{1'b1, 8'hFD, 8'h07, 4'h1, 18'h3FFEB, 1'b0, 18'h0};
    vecs[1] = '{1'b0, 8'hFF, 8'hFF, 4'h2, 18'h0FE01, 1'b1, 18'h0FF00};
    vecs[2] = '{1'b1, 8'h80, 8'h80, 4'h3, 18'h04000, 1'b1, 18'h0};
    vecs[3] = '{1'b1, 8'h7F, 8'h80, 4'h4, 18'h3C080, 1'b0, 18'h0};
    vecs[4] = '{1'b0, 8'h80, 8'h80, 4'h5, 18'h04000, 1'b0, 18'h0};
    vecs[5] = '{1'b1, 8'h00, 8'h55, 4'h6, 18'h00000, 1'b0, 18'h0};
    vecs[6] = '{1'b0, 8'h03, 8'hAA, 4'h7, 18'h001FE, 1'b0, 18'h0};
    vecs[7] = '{1'b1, 8'hFF, 8'hFF, 4'h8, 18'h00001, 1'b0, 18'h0};
    vecs[8] = '{1'b0, 8'hFF, 8'h00, 4'h9, 18'h00000, 1'b1, 18'h0};
    vecs[9] = '{1'b1, 8'h05, 8'hF9, 4'hA, 18'h3FFDD, 1'b0, 18'h0};

    ops4[0] = '{1'b0, 8'd2,  8'd3,  4'h1, 18'h00006, 1'b0, 18'h0};
    ops4[1] = '{1'b0, 8'd10, 8'd10, 4'h2, 18'h00064, 1'b0, 18'h0};
    ops4[2] = '{1'b1, 8'hFE, 8'd5,  4'h3, 18'h3FFF6, 1'b0, 18'h0};
    ops4[3] = '{1'b0, 8'hFF, 8'd1,  4'h4, 18'h000FF, 1'b0, 18'h0};

    reset = 1'b1;
    in_valid = 1'b0; in_signed = 1'b0; in_a = '0; in_b = '0; in_tag = '0; out_ready = 1'b1;
    c_in_valid = 1'b0; c_in_signed = 1'b0; c_in_a = '0; c_in_b = '0; c_in_tag = '0; c_out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_pp", out_pp, '0);
    check("reset_out_tag", out_tag, 4'h0);
    check("reset_in_ready", in_ready, 1'b1);

    // Directed vectors, one at a time with out_ready high.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      drive8(vecs[i].sgn, vecs[i].a, vecs[i].b, vecs[i].tag);
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!out_valid && lat < 10);
      check($sformatf("vec%0d_latency", i), 66'(lat), 66'd2);
      check($sformatf("vec%0d_sum", i), sum8(out_pp), vecs[i].exp_sum);
      check($sformatf("vec%0d_tag", i), out_tag, vecs[i].tag);
      if (vecs[i].chk4) check($sformatf("vec%0d_pp4", i), out_pp[4*PPW8 +: PPW8], vecs[i].exp_pp4);
      if (vecs[i].a != 0 && vecs[i].exp_sum == 0) check($sformatf("vec%0d_all_zero", i), out_pp, '0);
    end

    // Wide operands.
    all1 = '1;
    run32("w32_minmin", 1'b1, 32'h8000_0000, 32'h8000_0000, 4'hB, 66'h4000_0000_0000_0000);
    run32("w32_neg1", 1'b1, 32'hFFFF_FFFF, 32'h0000_0001, 4'hC, all1);
    run32("w32_umax", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'hD, 66'hFFFF_FFFE_0000_0001);

    // Back-pressure: out_ready low while four ops are offered back to back.
    @(negedge clk);
    idx = 0;
    held_pp = '0;
    held_tag = '0;
    for (int c = 0; c < 3; c++) begin
      if (c != 0) @(negedge clk);
      out_ready = 1'b0;
      drive8(ops4[idx].sgn, ops4[idx].a, ops4[idx].b, ops4[idx].tag);
      #1;
      rdy = in_ready;
      if (c == 2) begin held_pp = out_pp; held_tag = out_tag; end
      @(posedge clk); #1;
      if (rdy) idx++;
    end
    check("bp_accepted", 66'(idx), 66'd2);
    @(negedge clk); #1;
    check("bp_in_ready_low", in_ready, 1'b0);
    check("bp_out_valid", out_valid, 1'b1);
    check("bp_pp_stable", out_pp, held_pp);
    check("bp_tag_stable", out_tag, held_tag);
    check("bp_head_tag", out_tag, 4'h1);
    @(posedge clk); #1;

    ngot = 0; first_c = -1; last_c = -1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      if (idx < 4) drive8(ops4[idx].sgn, ops4[idx].a, ops4[idx].b, ops4[idx].tag);
      else in_valid = 1'b0;
      #1;
      rdy = in_ready && in_valid;
      if (out_valid) begin
        if (ngot < 8) begin got_tag[ngot] = out_tag; got_sum[ngot] = sum8(out_pp); end
        if (first_c < 0) first_c = c;
        last_c = c;
        ngot++;
      end
      @(posedge clk); #1;
      if (rdy) idx++;
    end
    in_valid = 1'b0;
    check("bp_out_count", 66'(ngot), 66'd4);
    check("bp_no_bubble", 66'(last_c - first_c), 66'd3);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp_order_tag%0d", k), got_tag[k], ops4[k].tag);
      check($sformatf("bp_order_sum%0d", k), got_sum[k], ops4[k].exp_sum);
    end

    // Reset with both stages full: nothing stale may emerge.
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      drive8(ops4[c].sgn, ops4[c].a, ops4[c].b, ops4[c].tag);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk); #1;
    check("rst_pre_in_ready", in_ready, 1'b0);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_pp", out_pp, '0);
    check("rst_out_tag", out_tag, 4'h0);
    check("rst_in_ready", in_ready, 1'b1);
    seen = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("rst_no_stale", 66'(seen), 66'd0);

    // Random traffic against a multiplication model and an in-order scoreboard.
    sent = 0; got = 0; cyc = 0;
    while ((sent < 300 || got < sent) && cyc < 5000) begin
      @(negedge clk);
      if (!in_valid && sent < 300 && $urandom_range(0, 3) != 0)
        drive8(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 4'(sent));
      out_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc_in  = in_valid && in_ready;
      acc_out = out_valid && out_ready;
      if (acc_out) begin
        if (sbq.size() == 0) begin
          check("rand_unexpected_output", 66'd1, 66'd0);
        end else begin
          e = sbq.pop_front();
          check($sformatf("rand%0d_tag", got), out_tag, e.tag);
          check($sformatf("rand%0d_sum", got), sum8(out_pp), e.exp_sum);
        end
        got++;
      end
      if (acc_in) begin
        av = in_signed ? int'($signed(in_a)) : int'(in_a);
        bv = in_signed ? int'($signed(in_b)) : int'(in_b);
        prod = av * bv;
        e.tag = in_tag;
        e.exp_sum = prod[PPW8-1:0];
        sbq.push_back(e);
        sent++;
      end
      @(posedge clk); #1;
      if (acc_in) in_valid = 1'b0;
      cyc++;
    end
    check("rand_sent", 66'(sent), 66'd300);
    check("rand_drained", 66'(got), 66'd300);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors + 1);
    $fatal(1, "watchdog");
  end

endmodule
